// File: rtl/regfile_pkg.sv
// Shared sizing and types for the LEGv8 integer register file.
// X31 (XZR) has no storage and always reads zero.
package regfile_pkg;

    localparam int WIDTH    = 64;
    localparam int NREGS    = 32;
    localparam int AW       = $clog2(NREGS);
    localparam int ZERO_REG = 31;

    typedef logic [WIDTH-1:0] word_t;
    typedef logic [AW-1:0]    regaddr_t;

endpackage

// File: rtl/reg_word.sv
// One register word: WIDTH enable-gated flops with synchronous active-high clear.
// Latency 1 from i_en/i_d to o_q; no backpressure, the write is always taken.
module reg_word #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    // Clear wins over a same-edge write.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/regfile_dff.sv
// Integer register file: 2 combinational read ports, 1 write port, X31 reads zero.
// Write latency 1, read latency 0, no bypass; no backpressure, writes are always accepted.
module regfile_dff
    import regfile_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr1,
    input  logic [AW-1:0]    rd_addr2,
    output logic [WIDTH-1:0] rd_data1,
    output logic [WIDTH-1:0] rd_data2
);

    word_t w_words [NREGS];

    // The zero register gets no flops, so writes to it vanish by construction.
    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_word
            if (gi == ZERO_REG) begin : g_zero
                assign w_words[gi] = '0;
            end else begin : g_reg
                logic w_word_en;
                assign w_word_en = wr_en && (wr_addr == regaddr_t'(gi));

                reg_word #(
                    .WIDTH(WIDTH)
                ) u_word (
                    .clk   (clk),
                    .reset (reset),
                    .i_en  (w_word_en),
                    .i_d   (wr_data),
                    .o_q   (w_words[gi])
                );
            end
        end
    endgenerate

    assign rd_data1 = (rd_addr1 == regaddr_t'(ZERO_REG)) ? '0 : w_words[rd_addr1];
    assign rd_data2 = (rd_addr2 == regaddr_t'(ZERO_REG)) ? '0 : w_words[rd_addr2];

endmodule

// File: tb/tb_regfile_dff.sv
// Bench for regfile_dff: directed scenarios plus random traffic against an array model.
module tb_regfile_dff;

    logic        clk;
    logic        reset;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [63:0] wr_data;
    logic [4:0]  rd_addr1;
    logic [4:0]  rd_addr2;
    logic [63:0] rd_data1;
    logic [63:0] rd_data2;

    int total = 0;
    int bad   = 0;

    logic [63:0] model [32];

    regfile_dff dut (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_addr1 (rd_addr1),
        .rd_addr2 (rd_addr2),
        .rd_data1 (rd_data1),
        .rd_data2 (rd_data2)
    );

    initial clk = 1'b0;
    always #100 clk = ~clk;

    function automatic logic [63:0] expect_rd(input logic [4:0] a);
        return (a == 5'd31) ? 64'h0 : model[a];
    endfunction

    // One clock edge; the model applies the architectural rules to the inputs seen at that edge.
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 32; i++) model[i] = 64'h0;
        end else if (wr_en && wr_addr != 5'd31) begin
            model[wr_addr] = wr_data;
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; wr_en = 1'b1; wr_addr = 5'd3; wr_data = 64'h1234;
        tick();
        tick();
        reset = 1'b0; wr_en = 1'b0;
        for (int a = 0; a < 32; a++) begin
            rd_addr1 = 5'(a); rd_addr2 = 5'(31 - a);
            #2;
            total += 2;
            if (rd_data1 !== 64'h0) begin
                bad++; $display("FAIL reset_rd1 addr=%0d got=%h exp=0", a, rd_data1);
            end
            if (rd_data2 !== 64'h0) begin
                bad++; $display("FAIL reset_rd2 addr=%0d got=%h exp=0", 31 - a, rd_data2);
            end
        end
    endtask

    task automatic test_write_pair();
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 64'hDEADBEEF_CAFEF00D;
        tick();
        wr_addr = 5'd6; wr_data = 64'h1;
        tick();
        wr_en = 1'b0;
        rd_addr1 = 5'd5; rd_addr2 = 5'd6;
        #2;
        total += 2;
        if (rd_data1 !== 64'hDEADBEEF_CAFEF00D) begin
            bad++; $display("FAIL write_x5 got=%h exp=deadbeefcafef00d", rd_data1);
        end
        if (rd_data2 !== 64'h1) begin
            bad++; $display("FAIL write_x6 got=%h exp=1", rd_data2);
        end
        for (int a = 0; a < 32; a++) begin
            rd_addr1 = 5'(a);
            #2;
            total++;
            if (rd_data1 !== expect_rd(5'(a))) begin
                bad++; $display("FAIL write_others addr=%0d got=%h exp=%h", a, rd_data1, expect_rd(5'(a)));
            end
        end
    endtask

    task automatic test_zero_reg();
        wr_en = 1'b1; wr_addr = 5'd31; wr_data = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        wr_en = 1'b0;
        for (int a = 0; a < 32; a++) begin
            rd_addr1 = 5'(a); rd_addr2 = 5'd31;
            #2;
            total += 2;
            if (rd_data1 !== expect_rd(5'(a))) begin
                bad++; $display("FAIL xzr_others addr=%0d got=%h exp=%h", a, rd_data1, expect_rd(5'(a)));
            end
            if (rd_data2 !== 64'h0) begin
                bad++; $display("FAIL xzr_read got=%h exp=0", rd_data2);
            end
        end
    endtask

    task automatic test_wr_disable();
        wr_en = 1'b0; wr_addr = 5'd7; wr_data = 64'h55;
        tick();
        rd_addr1 = 5'd7; rd_addr2 = 5'd5;
        #2;
        total += 2;
        if (rd_data1 !== 64'h0) begin
            bad++; $display("FAIL wr_disable_x7 got=%h exp=0", rd_data1);
        end
        if (rd_data2 !== 64'hDEADBEEF_CAFEF00D) begin
            bad++; $display("FAIL wr_disable_x5 got=%h exp=deadbeefcafef00d", rd_data2);
        end
    endtask

    task automatic test_read_during_write();
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 64'hA;
        tick();
        wr_data = 64'hB; rd_addr1 = 5'd9; rd_addr2 = 5'd9;
        #2;
        total += 2;
        if (rd_data1 !== 64'hA) begin
            bad++; $display("FAIL rdw_before got=%h exp=a", rd_data1);
        end
        if (rd_data2 !== 64'hA) begin
            bad++; $display("FAIL rdw_before_p2 got=%h exp=a", rd_data2);
        end
        tick();
        wr_en = 1'b0;
        #2;
        total += 2;
        if (rd_data1 !== 64'hB) begin
            bad++; $display("FAIL rdw_after got=%h exp=b", rd_data1);
        end
        if (rd_data2 !== 64'hB) begin
            bad++; $display("FAIL rdw_after_p2 got=%h exp=b", rd_data2);
        end
    endtask

    task automatic test_reset_mid_write();
        wr_en = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            wr_addr = 5'(i); wr_data = 64'(i * 3);
            tick();
        end
        wr_en = 1'b0;
        for (int a = 1; a <= 30; a++) begin
            rd_addr1 = 5'(a);
            #2;
            total++;
            if (rd_data1 !== 64'(a * 3)) begin
                bad++; $display("FAIL load_idx3 addr=%0d got=%h exp=%h", a, rd_data1, 64'(a * 3));
            end
        end
        reset = 1'b1; wr_en = 1'b1; wr_addr = 5'd2; wr_data = 64'h77;
        tick();
        reset = 1'b0; wr_en = 1'b0;
        for (int a = 0; a < 32; a++) begin
            rd_addr1 = 5'(a); rd_addr2 = 5'(a ^ 5);
            #2;
            total += 2;
            if (rd_data1 !== 64'h0) begin
                bad++; $display("FAIL reset_mid_write addr=%0d got=%h exp=0", a, rd_data1);
            end
            if (rd_data2 !== 64'h0) begin
                bad++; $display("FAIL reset_mid_write_p2 addr=%0d got=%h exp=0", a ^ 5, rd_data2);
            end
        end
    endtask

    task automatic test_random();
        logic [63:0] e1, e2;
        for (int n = 0; n < 400; n++) begin
            reset    = ($urandom_range(0, 39) == 0);
            wr_en    = $urandom_range(0, 3) != 0;
            wr_addr  = 5'($urandom_range(0, 31));
            wr_data  = {$urandom, $urandom};
            rd_addr1 = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
            rd_addr2 = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
            #2;
            e1 = expect_rd(rd_addr1); e2 = expect_rd(rd_addr2);
            total += 2;
            if (rd_data1 !== e1) begin
                bad++; $display("FAIL rand_pre_rd1 n=%0d addr=%0d got=%h exp=%h", n, rd_addr1, rd_data1, e1);
            end
            if (rd_data2 !== e2) begin
                bad++; $display("FAIL rand_pre_rd2 n=%0d addr=%0d got=%h exp=%h", n, rd_addr2, rd_data2, e2);
            end
            tick();
            #2;
            e1 = expect_rd(rd_addr1); e2 = expect_rd(rd_addr2);
            total += 2;
            if (rd_data1 !== e1) begin
                bad++; $display("FAIL rand_post_rd1 n=%0d addr=%0d got=%h exp=%h", n, rd_addr1, rd_data1, e1);
            end
            if (rd_data2 !== e2) begin
                bad++; $display("FAIL rand_post_rd2 n=%0d addr=%0d got=%h exp=%h", n, rd_addr2, rd_data2, e2);
            end
        end
        reset = 1'b0; wr_en = 1'b0;
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rd_addr1 = '0; rd_addr2 = '0;
        for (int i = 0; i < 32; i++) model[i] = 64'h0;
        #1;
        test_reset();
        test_write_pair();
        test_zero_reg();
        test_wr_disable();
        test_read_during_write();
        test_reset_mid_write();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
